// File: rtl/impulse_response_recorder.sv
// Records DEPTH mic samples following an impulse marker and measures the
// round-trip delay (first threshold crossing) and peak magnitude of the response.
module impulse_response_recorder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [15:0] THRESHOLD = 16'd4096
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     step_in,
  input  logic                     impulse_in,
  input  logic signed [15:0]       amp_in,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_in,
  output logic signed [15:0]       rd_data_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     detected_out,
  output logic [$clog2(DEPTH)-1:0] delay_out,
  output logic [15:0]              peak_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          detected_q, detected_d;
  logic [AW-1:0] delay_q, delay_d;
  logic [DW-1:0] peak_q, peak_d;

  logic          wr_en_c;
  logic [DW-1:0] amp_u_c;
  logic [DW-1:0] mag_c;

  logic signed [DW-1:0] mem_q [DEPTH];
  logic signed [DW-1:0] rd_data_q;

  // Two's-complement magnitude; -32768 maps to 0x8000 = 32768 without saturation.
  always_comb begin
    amp_u_c = DW'(amp_in);
    mag_c   = amp_in[DW-1] ? (~amp_u_c + DW'(1)) : amp_u_c;
  end

  // Next-state and result update logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    detected_d = detected_q;
    delay_d    = delay_q;
    peak_d     = peak_q;
    wr_en_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (impulse_in) begin
          state_d    = S_CAPTURE;
          idx_d      = '0;
          detected_d = 1'b0;
          delay_d    = '0;
          peak_d     = '0;
        end
      end

      S_CAPTURE: begin
        if (step_in) begin
          wr_en_c = 1'b1;
          idx_d   = idx_q + AW'(1);
          if (mag_c > peak_q) begin
            peak_d = mag_c;
          end
          // Only the first crossing sets the delay.
          if (!detected_q && (mag_c >= THRESHOLD)) begin
            detected_d = 1'b1;
            delay_d    = idx_q;
          end
          if (idx_q == AW'(DEPTH - 1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      detected_q <= 1'b0;
      delay_q    <= '0;
      peak_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      detected_q <= detected_d;
      delay_q    <= delay_d;
      peak_q     <= peak_d;
    end
  end

  // Response buffer write port; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (wr_en_c) begin
      mem_q[idx_q] <= amp_in;
    end
  end

  // Registered read port, read-first on a same-address write.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_in];
    end
  end

  assign rd_data_out  = rd_data_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign detected_out = detected_q;
  assign delay_out    = delay_q;
  assign peak_out     = peak_q;

endmodule

// File: tb/tb_impulse_response_recorder.sv
// Randomized scoreboard bench for impulse_response_recorder (DEPTH=16).
module tb_impulse_response_recorder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int          THR   = 4096;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 step_in;
  logic                 impulse_in;
  logic signed [15:0]   amp_in;
  logic [AW-1:0]        rd_addr_in;
  logic signed [15:0]   rd_data_out;
  logic                 busy_out;
  logic                 done_out;
  logic                 detected_out;
  logic [AW-1:0]        delay_out;
  logic [15:0]          peak_out;

  impulse_response_recorder #(
    .DEPTH    (DEPTH),
    .THRESHOLD(16'd4096)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .step_in     (step_in),
    .impulse_in  (impulse_in),
    .amp_in      (amp_in),
    .rd_addr_in  (rd_addr_in),
    .rd_data_out (rd_data_out),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .detected_out(detected_out),
    .delay_out   (delay_out),
    .peak_out    (peak_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int det;
    int dly;
    int pk;
  } res_t;

  res_t               exp_q[$];
  int                 rd_q[$];
  logic signed [15:0] smp    [DEPTH];
  logic signed [15:0] tb_mem [DEPTH];
  bit                 vld    [DEPTH];
  bit                 rd_pend = 1'b0;
  bit                 rd_chk  = 1'b0;
  int                 errors  = 0;
  int                 checks  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reference: results follow directly from the captured sample list.
  function automatic res_t model();
    res_t r;
    int   m;
    r.det = 0;
    r.dly = 0;
    r.pk  = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      m = (smp[i] < 0) ? -int'(smp[i]) : int'(smp[i]);
      if (m > r.pk) r.pk = m;
      if (r.det == 0 && m >= THR) begin
        r.det = 1;
        r.dly = i;
      end
    end
    return r;
  endfunction

  // Monitor: scores result sets on done pulses and read data one cycle after a request.
  always @(posedge clk_in) rd_chk <= rd_pend;

  always @(negedge clk_in) begin
    res_t e;
    int   r;
    if (done_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("detected", int'(detected_out), e.det);
        check("delay", int'(delay_out), e.dly);
        check("peak", int'(peak_out), e.pk);
      end
    end
    if (rd_chk) begin
      if (rd_q.size() == 0) begin
        check("unexpected_read", 1, 0);
      end else begin
        r = rd_q.pop_front();
        check("rd_data", int'(rd_data_out), r);
      end
    end
  end

  task automatic read_addr(input int a);
    rd_addr_in = AW'(a);
    rd_q.push_back(int'(tb_mem[a]));
    rd_pend = 1'b1;
    tick();
    rd_pend = 1'b0;
  endtask

  task automatic run_capture(input int period, input bit coincident,
                             input logic signed [15:0] cval, input bit mid_imp,
                             input int abort_at, input bit rw_same);
    res_t e;
    e = model();
    impulse_in = 1'b1;
    step_in    = coincident;
    amp_in     = cval;
    tick();
    impulse_in = 1'b0;
    step_in    = 1'b0;
    check("busy_after_impulse", int'(busy_out), 1);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i == abort_at) begin
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("abort_busy", int'(busy_out), 0);
        check("abort_done", int'(done_out), 0);
        check("abort_detected", int'(detected_out), 0);
        check("abort_delay", int'(delay_out), 0);
        check("abort_peak", int'(peak_out), 0);
        repeat (3) tick();
        return;
      end
      for (int k = 0; k < period - 1; k++) begin
        amp_in     = 16'($urandom);
        impulse_in = (mid_imp && i == 5 && k == 0);
        tick();
        impulse_in = 1'b0;
      end
      step_in = 1'b1;
      amp_in  = smp[i];
      if (rw_same && vld[i]) begin
        rd_addr_in = AW'(i);
        rd_q.push_back(int'(tb_mem[i]));
        rd_pend = 1'b1;
      end
      if (i == int'(DEPTH) - 1) exp_q.push_back(e);
      tick();
      step_in   = 1'b0;
      rd_pend   = 1'b0;
      tb_mem[i] = smp[i];
      vld[i]    = 1'b1;
    end
    check("done_timing", int'(done_out), 1);
    check("busy_in_done", int'(busy_out), 0);
    tick();
    check("done_single", int'(done_out), 0);
    check("busy_idle", int'(busy_out), 0);
    check("hold_peak", int'(peak_out), e.pk);
    check("hold_delay", int'(delay_out), e.dly);
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ($urandom_range(0, 3) == 0) smp[i] = 16'($urandom);
      else smp[i] = 16'($urandom_range(0, 6000) - 3000);
    end
  endtask

  initial begin
    step_in    = 1'b0;
    impulse_in = 1'b0;
    amp_in     = '0;
    rd_addr_in = '0;
    for (int i = 0; i < int'(DEPTH); i++) vld[i] = 1'b0;

    // Reset with random inputs
    rst_in = 1'b1;
    repeat (2) begin
      step_in    = 1'($urandom);
      impulse_in = 1'($urandom);
      amp_in     = 16'($urandom);
      rd_addr_in = AW'($urandom);
      tick();
    end
    check("rst_busy", int'(busy_out), 0);
    check("rst_done", int'(done_out), 0);
    check("rst_detected", int'(detected_out), 0);
    check("rst_delay", int'(delay_out), 0);
    check("rst_peak", int'(peak_out), 0);
    check("rst_rd_data", int'(rd_data_out), 0);
    rst_in     = 1'b0;
    step_in    = 1'b0;
    impulse_in = 1'b0;
    tick();

    // Crossing at 10, larger peak at 11, step every 4 cycles
    for (int i = 0; i < int'(DEPTH); i++) smp[i] = 16'sd0;
    smp[10] = 16'sd5000;
    smp[11] = -16'sd8000;
    run_capture(4, 1'b0, 16'sd0, 1'b0, -1, 1'b0);
    read_addr(11);
    read_addr(10);
    read_addr(0);

    // Below threshold everywhere, step every cycle, read-during-write
    for (int i = 0; i < int'(DEPTH); i++) smp[i] = 16'sd100;
    run_capture(1, 1'b0, 16'sd0, 1'b0, -1, 1'b1);
    read_addr(3);

    // Threshold boundary: 4095 no, 4096 yes
    for (int i = 0; i < int'(DEPTH); i++) smp[i] = 16'sd100;
    smp[2] = 16'sd4095;
    smp[3] = 16'sd4096;
    smp[7] = -16'sd5000;
    run_capture(3, 1'b0, 16'sd0, 1'b0, -1, 1'b0);

    // Most negative sample
    for (int i = 0; i < int'(DEPTH); i++) smp[i] = 16'($urandom_range(0, 2000) - 1000);
    smp[5] = -16'sd32768;
    run_capture(2, 1'b0, 16'sd0, 1'b0, -1, 1'b1);
    read_addr(5);

    // Coincident step not captured; mid-capture impulse ignored
    for (int i = 0; i < int'(DEPTH); i++) smp[i] = 16'sd0;
    run_capture(2, 1'b1, 16'sd7000, 1'b1, -1, 1'b0);
    read_addr(0);

    // Abort by reset at index 7, then a fresh capture
    fill_random();
    run_capture(2, 1'b0, 16'sd0, 1'b0, 7, 1'b0);
    fill_random();
    run_capture(2, 1'b0, 16'sd0, 1'b0, -1, 1'b0);

    // Random captures
    for (int n = 0; n < 4; n++) begin
      fill_random();
      run_capture(int'($urandom_range(1, 3)), 1'($urandom), 16'($urandom), 1'b0, -1, n[0]);
      for (int r = 0; r < 3; r++) read_addr(int'($urandom_range(0, DEPTH - 1)));
    end

    repeat (4) tick();
    check("exp_queue_empty", exp_q.size(), 0);
    check("rd_queue_empty", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
